pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and stall controller for the four-stage pipeline's register boundaries: IF/ID, ID/EX, EX/MEM and MEM/WB. Each boundary is a lockable pipeline buffer whose `flush` input has priority over its `dis` input. Each cycle this block detects load-use hazards, taken branches, multi-cycle multiply/divide occupancy and data-memory wait. From these it drives the PC enable and the `dis`/`flush` pair of every boundary buffer. It is the sole source of those control lines.

## Interface
- `REG_ADDR_W`, 4: register-address width.
- `MULDIV_CYCLES`, 4: cycles a mul/div instruction occupies EX; must be ≥ 2.
- `PERF_W`, 16: width of the performance counters (only with `HAZARD_PERF_CNT_EN`).

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W: source registers of the instruction in ID.
- `id_rs_valid`  in  2: bit0 qualifies `id_rs1`, bit1 qualifies `id_rs2`.
- `ex_rd`  in  REG_ADDR_W: destination register of the instruction in EX.
- `ex_mem_read`  in  1: the EX instruction is a load.
- `ex_branch_taken`  in  1: the EX instruction redirects the PC.
- `ex_muldiv_start`  in  1: the EX instruction is a multi-cycle mul/div.
- `mem_wait`  in  1: data memory is not ready; freeze the whole pipe.
- `pc_en`  out  1: PC register load enable.
- `ifid_dis`, `idex_dis`, `exmem_dis`, `memwb_dis`  out  1 each: buffer hold.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each: buffer clear.
- `busy`  out  1: state is MULDIV.
- `stall_cnt`, `flush_cnt`  out  PERF_W each: present only with `HAZARD_PERF_CNT_EN`.

## Operation
- State register has two states: RUN and MULDIV. There is also a down-counter `cnt` of width clog2(MULDIV_CYCLES).
- Reset cycle (`rst_n`=0):
  - All four flush outputs are 1, all dis outputs are 0, `pc_en`=0.
  - At the edge, state becomes RUN, `cnt` becomes 0, and perf counters clear.
- Load-use hazard, `lu`: `ex_mem_read` & `ex_rd`≠0 & ((`id_rs_valid`[0] & `id_rs1`==`ex_rd`) | (`id_rs_valid`[1] & `id_rs2`==`ex_rd`)).
- Default in RUN: `pc_en`=1, every dis and flush output is 0.
- Conditions in RUN, highest priority first:
  1. `mem_wait`: all four dis=1, all flush=0, `pc_en`=0. No state change, even if `ex_muldiv_start` is high.
  2. `ex_muldiv_start`: `ifid_dis`=1, `idex_dis`=1, `exmem_flush`=1, `pc_en`=0. At the edge, `cnt` ← MULDIV_CYCLES−2 and state ← MULDIV.
  3. `ex_branch_taken`: `ifid_flush`=1, `idex_flush`=1, `pc_en`=1 (the PC loads the branch target).
  4. `lu`: `ifid_dis`=1, `idex_flush`=1, `pc_en`=0. This inserts one bubble; the load then advances and forwarding resolves it.
- MULDIV state:
  - While `cnt`≠0, outputs match the `ex_muldiv_start` cycle and `cnt` decrements each cycle.
  - `cnt` also decrements during `mem_wait`; in that case all four dis=1 and all flush=0 take precedence.
  - At `cnt`==0 with `mem_wait`=0: outputs are the RUN defaults, the mul/div instruction leaves EX, and state ← RUN.
  - At `cnt`==0 with `mem_wait`=1: all dis=1, and the block stays in MULDIV at `cnt`=0 until `mem_wait` drops.
  - `ex_muldiv_start`, `ex_branch_taken` and `lu` are ignored in MULDIV.
- Invariant: no boundary ever has dis and flush both asserted.
- Reset asserted mid-MULDIV: the next state is RUN and the reset outputs apply immediately.

## Timing
- All hazard and stall outputs are Mealy: combinational from state, `cnt` and inputs. The buffers act on them at the same rising edge, giving zero-cycle latency.
- `busy` is a decode of the registered state.
- With no `mem_wait`, a mul/div instruction occupies EX for exactly MULDIV_CYCLES cycles. `pc_en` is low for MULDIV_CYCLES−1 of them.
- A load-use stall lasts 1 cycle. A branch costs 2 flushed slots and no stall cycle.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments, saturating, on every non-reset cycle with `pc_en`=0.
  - `flush_cnt` increments, saturating, on every non-reset cycle where `ex_branch_taken` is acted on, i.e. RUN without `mem_wait` or `ex_muldiv_start`.
  - Both counters clear on reset.
- Not defined: both ports and all counter logic are absent. Control behaviour is identical.

## Structure
- Package `hazard_pkg` holds the state encodings: ST_RUN=1'b0 and ST_MULDIV=1'b1.
- Sub-module `hazard_perf_cnt` implements one saturating PERF_W counter with `clk`, `rst_n`, `inc` and `count`. It is instantiated twice, only under the macro.

## Test plan
- `rst_n`=0 for 2 cycles → all flush=1, all dis=0, `pc_en`=0; `busy`=0 after release.
- `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_rs_valid`=01 → one cycle of `pc_en`=0, `ifid_dis`=1, `idex_flush`=1. The same stimulus with `ex_rd`=0 → no stall.
- `lu` and `ex_branch_taken` together → `ifid_flush`=1, `idex_flush`=1, `pc_en`=1, `ifid_dis`=0.
- MULDIV_CYCLES=4, `ex_muldiv_start` at cycle t → `exmem_flush`=1 and `pc_en`=0 in t..t+2, released at t+3; `busy`=1 in t+1..t+3.
- `mem_wait`=1 for 2 cycles while in MULDIV at `cnt`=0 → all dis=1, no flush, `busy` stays 1; RUN the cycle after `mem_wait` drops.
- With the macro, PERF_W=4: 20 stall cycles → `stall_cnt`=15 (saturated); 3 branch flushes → `flush_cnt`=3.

Source files
------------

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard/stall controller.
//   - hz_state_e : controller state encoding (RUN / MULDIV)
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } hz_state_e;

endpackage : hazard_pkg

// File: rtl/hazard_perf_cnt.sv
// -----------------------------------------------------------------------------
// hazard_perf_cnt
// Saturating event counter used for hazard performance statistics.
// Ports:
//   clk    in  1       : rising-edge clock
//   rst_n  in  1       : synchronous active-low reset (clears the count)
//   inc    in  1       : count one event this cycle
//   count  out PERF_W  : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module hazard_perf_cnt #(
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    logic [PERF_W-1:0] count_d;
    logic [PERF_W-1:0] count_q;

    // Next count: hold at the maximum value instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {PERF_W{1'b1}})) begin
            count_d = count_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= {PERF_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : hazard_perf_cnt

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and stall controller for a four-stage pipeline (IF/ID, ID/EX,
// EX/MEM, MEM/WB boundaries). Detects load-use hazards, taken branches,
// multi-cycle mul/div occupancy of EX and data-memory wait, and drives the
// PC enable plus the dis (hold) / flush (clear) pair of every boundary.
// All control outputs are combinational (Mealy) so the buffers act on them
// at the same clock edge.
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt
// saturating counters and the PERF_W parameter.
//
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   id_rs1, id_rs2, id_rs_valid    : ID-stage source registers + qualifiers
//   ex_rd, ex_mem_read             : EX-stage destination, EX is a load
//   ex_branch_taken                : EX redirects the PC
//   ex_muldiv_start                : EX holds a multi-cycle mul/div
//   mem_wait                       : data memory not ready, freeze pipe
//   pc_en                          : PC load enable
//   *_dis / *_flush                : per-boundary hold / clear
//   busy                           : controller is in MULDIV
//   stall_cnt, flush_cnt           : perf counters (macro only)
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W    = 4,
    parameter int MULDIV_CYCLES = 4
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int PERF_W        = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [1:0]            id_rs_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_muldiv_start,
    input  logic                  mem_wait,
    output logic                  pc_en,
    output logic                  ifid_dis,
    output logic                  idex_dis,
    output logic                  exmem_dis,
    output logic                  memwb_dis,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic                  memwb_flush,
    output logic                  busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     stall_cnt,
    output logic [PERF_W-1:0]     flush_cnt
`endif
);

    localparam int CNT_W = $clog2(MULDIV_CYCLES);
    // Loaded on entry to MULDIV: the start cycle itself is the first of
    // MULDIV_CYCLES, and the cnt==0 cycle is the last, so load CYCLES-2.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

    hz_state_e        state_d;
    hz_state_e        state_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic             lu_s;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    always_comb begin
        lu_s = 1'b0;
        if (ex_mem_read && (ex_rd != {REG_ADDR_W{1'b0}})) begin
            lu_s = (id_rs_valid[0] && (id_rs1 == ex_rd)) ||
                   (id_rs_valid[1] && (id_rs2 == ex_rd));
        end else begin
            lu_s = 1'b0;
        end
    end

    // Next-state and Mealy control outputs; defaults are the RUN free-flow values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_dis    = 1'b0;
        idex_dis    = 1'b0;
        exmem_dis   = 1'b0;
        memwb_dis   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;

        if (!rst_n) begin
            // Reset overrides everything, including an in-flight mul/div.
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_wait) begin
                        pc_en     = 1'b0;
                        ifid_dis  = 1'b1;
                        idex_dis  = 1'b1;
                        exmem_dis = 1'b1;
                        memwb_dis = 1'b1;
                    end else if (ex_muldiv_start) begin
                        // Hold the front of the pipe; bubble into MEM while EX is occupied.
                        pc_en       = 1'b0;
                        ifid_dis    = 1'b1;
                        idex_dis    = 1'b1;
                        exmem_flush = 1'b1;
                        cnt_d       = CNT_LOAD;
                        state_d     = ST_MULDIV;
                    end else if (ex_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (lu_s) begin
                        pc_en      = 1'b0;
                        ifid_dis   = 1'b1;
                        idex_flush = 1'b1;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
                ST_MULDIV: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        // The mul/div keeps running through a memory wait.
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (mem_wait) begin
                            pc_en     = 1'b0;
                            ifid_dis  = 1'b1;
                            idex_dis  = 1'b1;
                            exmem_dis = 1'b1;
                            memwb_dis = 1'b1;
                        end else begin
                            pc_en       = 1'b0;
                            ifid_dis    = 1'b1;
                            idex_dis    = 1'b1;
                            exmem_flush = 1'b1;
                        end
                    end else if (mem_wait) begin
                        // Result ready but the pipe is frozen: park at cnt==0.
                        pc_en     = 1'b0;
                        ifid_dis  = 1'b1;
                        idex_dis  = 1'b1;
                        exmem_dis = 1'b1;
                        memwb_dis = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and occupancy counter registers (reset handled in next-state logic).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == ST_MULDIV);

`ifdef HAZARD_PERF_CNT_EN
    logic stall_inc_s;
    logic flush_inc_s;

    // A branch is only acted on in RUN when nothing of higher priority is pending.
    always_comb begin
        stall_inc_s = rst_n && !pc_en;
        flush_inc_s = rst_n && (state_q == ST_RUN) && !mem_wait &&
                      !ex_muldiv_start && ex_branch_taken;
    end

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc_s),
        .count (stall_cnt)
    );

    hazard_perf_cnt #(.PERF_W(PERF_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc_s),
        .count (flush_cnt)
    );
`endif

endmodule : pipe_hazard_ctrl

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed self-checking bench for pipe_hazard_ctrl (MULDIV_CYCLES=4).
// Outputs are compared as one vector:
//   {pc_en, ifid_dis, idex_dis, exmem_dis, memwb_dis,
//    ifid_flush, idex_flush, exmem_flush, memwb_flush, busy}
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic [1:0] id_rs_valid;
    logic       ex_mem_read, ex_branch_taken, ex_muldiv_start, mem_wait;
    logic       pc_en, ifid_dis, idex_dis, exmem_dis, memwb_dis;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_flush, busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [9:0] obs;
    assign obs = {pc_en, ifid_dis, idex_dis, exmem_dis, memwb_dis,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush, busy};

    localparam logic [9:0] O_RUN    = 10'b1_0000_0000_0;
    localparam logic [9:0] O_RST    = 10'b0_0000_1111_0;
    localparam logic [9:0] O_LU     = 10'b0_1000_0100_0;
    localparam logic [9:0] O_BR     = 10'b1_0000_1100_0;
    localparam logic [9:0] O_MDST   = 10'b0_1100_0010_0;
    localparam logic [9:0] O_MDBSY  = 10'b0_1100_0010_1;
    localparam logic [9:0] O_MDEND  = 10'b1_0000_0000_1;
    localparam logic [9:0] O_WAIT   = 10'b0_1111_0000_0;
    localparam logic [9:0] O_WAITB  = 10'b0_1111_0000_1;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_ADDR_W    (4),
        .MULDIV_CYCLES (4)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .PERF_W        (4)
`endif
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs_valid     (id_rs_valid),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .ex_muldiv_start (ex_muldiv_start),
        .mem_wait        (mem_wait),
        .pc_en           (pc_en),
        .ifid_dis        (ifid_dis),
        .idex_dis        (idex_dis),
        .exmem_dis       (exmem_dis),
        .memwb_dis       (memwb_dis),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .memwb_flush     (memwb_flush),
        .busy            (busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic [1:0] vld, input logic [3:0] rd,
                          input logic mr, input logic br, input logic md,
                          input logic mw);
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_rs_valid     = vld;
        ex_rd           = rd;
        ex_mem_read     = mr;
        ex_branch_taken = br;
        ex_muldiv_start = md;
        mem_wait        = mw;
        #1;
    endtask

    task automatic idle();
        set_in(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        n_cmp++;
        if (obs[9:1] !== O_RST[9:1]) begin
            n_err++; $display("FAIL reset_c0 got=%b exp=%b", obs[9:1], O_RST[9:1]);
        end
        tick();
        n_cmp++;
        if (obs !== O_RST) begin
            n_err++; $display("FAIL reset_c1 got=%b exp=%b", obs, O_RST);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_RUN) begin
            n_err++; $display("FAIL reset_release got=%b exp=%b", obs, O_RUN);
        end
    endtask

    task automatic test_load_use();
        set_in(4'd5, 4'd0, 2'b01, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== O_LU) begin
            n_err++; $display("FAIL lu_rs1 got=%b exp=%b", obs, O_LU);
        end
        tick();
        idle();
        n_cmp++;
        if (obs !== O_RUN) begin
            n_err++; $display("FAIL lu_one_cycle got=%b exp=%b", obs, O_RUN);
        end
        set_in(4'd5, 4'd0, 2'b01, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== O_RUN) begin
            n_err++; $display("FAIL lu_rd0 got=%b exp=%b", obs, O_RUN);
        end
        set_in(4'd1, 4'd9, 2'b10, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== O_LU) begin
            n_err++; $display("FAIL lu_rs2 got=%b exp=%b", obs, O_LU);
        end
        set_in(4'd9, 4'd9, 2'b00, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== O_RUN) begin
            n_err++; $display("FAIL lu_invalid got=%b exp=%b", obs, O_RUN);
        end
        set_in(4'd9, 4'd0, 2'b01, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== O_RUN) begin
            n_err++; $display("FAIL lu_not_load got=%b exp=%b", obs, O_RUN);
        end
        tick();
    endtask

    task automatic test_branch();
        set_in(4'd5, 4'd0, 2'b01, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (obs !== O_BR) begin
            n_err++; $display("FAIL branch_over_lu got=%b exp=%b", obs, O_BR);
        end
        set_in(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (obs !== O_WAIT) begin
            n_err++; $display("FAIL wait_over_branch got=%b exp=%b", obs, O_WAIT);
        end
        tick();
        idle();
    endtask

    task automatic test_muldiv();
        logic [9:0] exp_seq [0:4];
        exp_seq[0] = O_MDST;
        exp_seq[1] = O_MDBSY;
        exp_seq[2] = O_MDBSY;
        exp_seq[3] = O_MDEND;
        exp_seq[4] = O_RUN;
        // Start stays high while the mul/div sits in EX; it must be ignored.
        for (int i = 0; i < 5; i++) begin
            set_in(4'd5, 4'd0, 2'b01, 4'd5, 1'b1, 1'b1, (i < 4) ? 1'b1 : 1'b0, 1'b0);
            if (i == 4) idle();
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++; $display("FAIL muldiv_t%0d got=%b exp=%b", i, obs, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_muldiv_memwait();
        logic [9:0] exp_seq [0:6];
        logic       mw_seq  [0:6];
        exp_seq[0] = O_MDST;  mw_seq[0] = 1'b0;
        exp_seq[1] = O_MDBSY; mw_seq[1] = 1'b0;
        exp_seq[2] = O_MDBSY; mw_seq[2] = 1'b0;
        exp_seq[3] = O_WAITB; mw_seq[3] = 1'b1;
        exp_seq[4] = O_WAITB; mw_seq[4] = 1'b1;
        exp_seq[5] = O_MDEND; mw_seq[5] = 1'b0;
        exp_seq[6] = O_RUN;   mw_seq[6] = 1'b0;
        for (int i = 0; i < 7; i++) begin
            set_in(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'b0, mw_seq[i]);
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++; $display("FAIL mdwait_end_t%0d got=%b exp=%b", i, obs, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_muldiv_wait_mid();
        logic [9:0] exp_seq [0:4];
        logic       mw_seq  [0:4];
        // The countdown keeps going during a wait, so release is not delayed.
        exp_seq[0] = O_MDST;  mw_seq[0] = 1'b0;
        exp_seq[1] = O_WAITB; mw_seq[1] = 1'b1;
        exp_seq[2] = O_MDBSY; mw_seq[2] = 1'b0;
        exp_seq[3] = O_MDEND; mw_seq[3] = 1'b0;
        exp_seq[4] = O_RUN;   mw_seq[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_in(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, (i == 0) ? 1'b1 : 1'b0, mw_seq[i]);
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++; $display("FAIL mdwait_mid_t%0d got=%b exp=%b", i, obs, exp_seq[i]);
            end
            tick();
        end
    endtask

    task automatic test_wait_blocks_start();
        set_in(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (obs !== O_WAIT) begin
            n_err++; $display("FAIL wait_over_start got=%b exp=%b", obs, O_WAIT);
        end
        tick();
        idle();
        n_cmp++;
        if (obs !== O_RUN) begin
            n_err++; $display("FAIL wait_no_state_change got=%b exp=%b", obs, O_RUN);
        end
        tick();
    endtask

    task automatic test_reset_mid_muldiv();
        set_in(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== (O_RST | 10'b0_0000_0000_1)) begin
            n_err++; $display("FAIL reset_mid_md got=%b exp=%b", obs, O_RST | 10'b0_0000_0000_1);
        end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs !== O_RUN) begin
            n_err++; $display("FAIL reset_mid_md_after got=%b exp=%b", obs, O_RUN);
        end
        tick();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ((stall_cnt !== 4'd0) || (flush_cnt !== 4'd0)) begin
            n_err++; $display("FAIL perf_clear got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
        end
        for (int i = 0; i < 20; i++) begin
            set_in(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        n_cmp++;
        if (stall_cnt !== 4'd15) begin
            n_err++; $display("FAIL perf_stall_sat got=%0d exp=15", stall_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            set_in(4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
        end
        idle();
        n_cmp++;
        if (flush_cnt !== 4'd3) begin
            n_err++; $display("FAIL perf_flush got=%0d exp=3", flush_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_muldiv_memwait();
        test_muldiv_wait_mid();
        test_wait_blocks_start();
        test_reset_mid_muldiv();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_hazard_ctrl
